// File: rtl/card_deal_bank.sv
// ---------------------------------------------------------------------------
// card_deal_bank
//
// Upstream feeder for the 7-segment card decoders. A free-running 1..CARD_MAX
// counter supplies pseudo-random card codes. Deal requests arrive on a
// valid/ready handshake, and each accepted card is stored in the next free
// slot of the player or dealer hand. A registered baccarat score is kept for
// each hand.
//
// Ports:
//   clk                  system clock, all state on the rising edge
//   reset                synchronous, active-high reset (overrides everything)
//   clear                synchronous hand clear for a new round
//   deal_valid           deal request
//   deal_to              target hand: 0 = player, 1 = dealer
//   deal_ready           request is accepted this cycle (combinational)
//   pcard1..pcard3       player slot codes (0 = blank, 1..13 = A..K)
//   dcard1..dcard3       dealer slot codes
//   pscore, dscore       baccarat score 0..9 of each hand
//   pcount, dcount       cards held 0..3
//   last_card            code of the most recently accepted card
//   force_card           (CARD_FORCE_EN only) overrides the counter when 1..13
//
// Optional build macro: CARD_FORCE_EN adds the force_card input so that benches
// can deal chosen cards. It is left undefined in board builds.
// ---------------------------------------------------------------------------
module card_deal_bank #(
  parameter int SLOTS    = 3,
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       deal_valid,
  input  logic       deal_to,
  output logic       deal_ready,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [1:0] pcount,
  output logic [1:0] dcount,
  output logic [3:0] last_card
`ifdef CARD_FORCE_EN
  ,
  input  logic [3:0] force_card
`endif
);

  localparam logic [3:0] CMAX = 4'(CARD_MAX);
  localparam logic [1:0] FULL = 2'(SLOTS);

  logic [3:0] ctr;
  logic [3:0] pslot [SLOTS];
  logic [3:0] dslot [SLOTS];
  logic [3:0] new_card;
  logic       accept;
  logic       accept_p;
  logic       accept_d;

  // Baccarat value of one card: face value for 1..9, zero for 10..K and blank.
  function automatic logic [4:0] card_val(input logic [3:0] c);
    return (c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  // Sum of up to three cards is at most 27, so two conditional subtractions
  // are enough to reduce it modulo 10.
  function automatic logic [3:0] hand_score(input logic [3:0] s [SLOTS]);
    logic [4:0] sum;
    sum = 5'd0;
    for (int i = 0; i < SLOTS; i++) sum = sum + card_val(s[i]);
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

  // Ready never looks at deal_valid, so the handshake has no combinational
  // loop through the requester.
  assign deal_ready = !clear && (deal_to ? (dcount != FULL) : (pcount != FULL));
  assign accept     = deal_valid && deal_ready;
  assign accept_p   = accept && !deal_to;
  assign accept_d   = accept &&  deal_to;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    new_card = ctr;
`ifdef CARD_FORCE_EN
    if (force_card >= 4'd1 && force_card <= CMAX) new_card = force_card;
`endif
  end

  // Free-running card source, unaffected by clear or deals.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)             ctr <= 4'd1;
    else if (ctr >= CMAX)  ctr <= 4'd1;
    else                   ctr <= ctr + 4'd1;
  end

  // Hand slots and counts. The slot array drives the decoders directly, so it
  // is reset like ordinary registers rather than treated as storage memory.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pcount <= 2'd0;
      dcount <= 2'd0;
      for (int i = 0; i < SLOTS; i++) begin
        pslot[i] <= 4'd0;
        dslot[i] <= 4'd0;
      end
    end else begin
      if (accept_p) pcount <= pcount + 2'd1;
      if (accept_d) dcount <= dcount + 2'd1;
      for (int i = 0; i < SLOTS; i++) begin
        if (accept_p && pcount == 2'(i)) pslot[i] <= new_card;
        if (accept_d && dcount == 2'(i)) dslot[i] <= new_card;
      end
    end
  end

  // last_card survives clear; only reset blanks it.
  always_ff @(posedge clk) begin
    if (reset)       last_card <= 4'd0;
    else if (accept) last_card <= new_card;
  end

  // Scores follow the slot registers one cycle later; clear zeroes them at
  // the same edge as the slots.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pscore <= 4'd0;
      dscore <= 4'd0;
    end else begin
      pscore <= hand_score(pslot);
      dscore <= hand_score(dslot);
    end
  end

  assign pcard1 = pslot[0];
  assign pcard2 = pslot[1];
  assign pcard3 = pslot[2];
  assign dcard1 = dslot[0];
  assign dcard2 = dslot[1];
  assign dcard3 = dslot[2];

endmodule

// File: tb/tb_card_deal_bank.sv
// ---------------------------------------------------------------------------
// tb_card_deal_bank
//
// Directed bench for card_deal_bank. A table of per-cycle vectors with
// hand-computed expected outputs walks through dealing, wrap of the card
// counter, full hands, score modulo and clear. Hand-written sequences cover
// reset override, reset mid-round and, when CARD_FORCE_EN is defined, the
// forced-card cases.
// ---------------------------------------------------------------------------
module tb_card_deal_bank;

  logic       clk = 1'b0;
  logic       reset, clear, deal_valid, deal_to;
  logic       deal_ready;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore, last_card;
  logic [1:0] pcount, dcount;
`ifdef CARD_FORCE_EN
  logic [3:0] force_card;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  string tag      = "";

  always #5 clk = ~clk;

  card_deal_bank dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .deal_valid (deal_valid),
    .deal_to    (deal_to),
    .deal_ready (deal_ready),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcount     (pcount),
    .dcount     (dcount),
    .last_card  (last_card)
`ifdef CARD_FORCE_EN
    ,
    .force_card (force_card)
`endif
  );

  typedef struct {
    logic       clr, v, to, rdy;
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic [1:0] pc, dc;
    logic [3:0] last;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input bit clr, v, to, rdy,
                              input int p1, p2, p3, d1, d2, d3,
                              input int ps, ds, pc, dc, last);
    vec_t r;
    r.clr = clr; r.v = v; r.to = to; r.rdy = rdy;
    r.p1 = 4'(p1); r.p2 = 4'(p2); r.p3 = 4'(p3);
    r.d1 = 4'(d1); r.d2 = 4'(d2); r.d3 = 4'(d3);
    r.ps = 4'(ps); r.ds = 4'(ds);
    r.pc = 2'(pc); r.dc = 2'(dc); r.last = 4'(last);
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic check_outs(input logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds,
                            input logic [1:0] pc, dc, input logic [3:0] last);
    check("pcard1", 8'(pcard1), 8'(p1));
    check("pcard2", 8'(pcard2), 8'(p2));
    check("pcard3", 8'(pcard3), 8'(p3));
    check("dcard1", 8'(dcard1), 8'(d1));
    check("dcard2", 8'(dcard2), 8'(d2));
    check("dcard3", 8'(dcard3), 8'(d3));
    check("pscore", 8'(pscore), 8'(ps));
    check("dscore", 8'(dscore), 8'(ds));
    check("pcount", 8'(pcount), 8'(pc));
    check("dcount", 8'(dcount), 8'(dc));
    check("last_card", 8'(last_card), 8'(last));
  endtask

  task automatic set_in(input bit r, c, v, to);
    reset = r; clear = c; deal_valid = v; deal_to = to;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input bit exp);
    #1;
    check("deal_ready", 8'(deal_ready), 8'(exp));
  endtask

  initial begin
    // Counter value at accepting edge k after reset release is ((k-1) mod 13)+1.
    tbl[0]  = mk(0,1,0,1,  1,0,0, 0,0,0, 0,0, 1,0, 1);
    tbl[1]  = mk(0,0,0,1,  1,0,0, 0,0,0, 1,0, 1,0, 1);
    tbl[2]  = mk(0,1,1,1,  1,0,0, 3,0,0, 1,0, 1,1, 3);
    tbl[3]  = mk(0,1,1,1,  1,0,0, 3,4,0, 1,3, 1,2, 4);
    tbl[4]  = mk(0,1,1,1,  1,0,0, 3,4,5, 1,7, 1,3, 5);
    tbl[5]  = mk(0,1,1,0,  1,0,0, 3,4,5, 1,2, 1,3, 5);   // dealer full
    tbl[6]  = mk(0,1,0,1,  1,7,0, 3,4,5, 1,2, 2,3, 7);
    tbl[7]  = mk(0,0,1,0,  1,7,0, 3,4,5, 8,2, 2,3, 7);
    tbl[8]  = mk(0,1,0,1,  1,7,9, 3,4,5, 8,2, 3,3, 9);
    tbl[9]  = mk(0,1,0,0,  1,7,9, 3,4,5, 7,2, 3,3, 9);   // 17 mod 10
    tbl[10] = mk(0,0,0,0,  1,7,9, 3,4,5, 7,2, 3,3, 9);
    tbl[11] = mk(1,1,0,0,  0,0,0, 0,0,0, 0,0, 0,0, 9);   // clear beats deal
    tbl[12] = mk(0,1,0,1, 13,0,0, 0,0,0, 0,0, 1,0, 13);  // counter at 13
    tbl[13] = mk(0,1,0,1, 13,1,0, 0,0,0, 0,0, 2,0, 1);   // wrapped to 1
    tbl[14] = mk(0,1,0,1, 13,1,2, 0,0,0, 1,0, 3,0, 2);
    tbl[15] = mk(0,1,1,1, 13,1,2, 3,0,0, 3,0, 3,1, 3);
    tbl[16] = mk(0,1,1,1, 13,1,2, 3,4,0, 3,3, 3,2, 4);
    tbl[17] = mk(0,1,0,0, 13,1,2, 3,4,0, 3,7, 3,2, 4);   // player full
    tbl[18] = mk(1,0,1,0,  0,0,0, 0,0,0, 0,0, 0,0, 4);
    tbl[19] = mk(0,0,0,1,  0,0,0, 0,0,0, 0,0, 0,0, 4);

`ifdef CARD_FORCE_EN
    force_card = 4'd0;
`endif

    // Reset held for two edges.
    tag = "reset";
    set_in(1, 0, 0, 0);
    tick();
    tick();
    check_outs(0,0,0, 0,0,0, 0,0, 0,0, 0);
    set_in(0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      tag = $sformatf("vec%0d", i);
      set_in(0, tbl[i].clr, tbl[i].v, tbl[i].to);
      check_ready(tbl[i].rdy);
      tick();
      check_outs(tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                 tbl[i].ps, tbl[i].ds, tbl[i].pc, tbl[i].dc, tbl[i].last);
    end

    // Fill three player and two dealer cards, then reset mid-round with clear
    // and a deal request also asserted.
    tag = "midround";
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, (i >= 3));
      tick();
    end
    set_in(0, 0, 0, 0);
    check("pcount", 8'(pcount), 8'd3);
    check("dcount", 8'(dcount), 8'd2);
    set_in(1, 1, 1, 0);
    tick();
    check_outs(0,0,0, 0,0,0, 0,0, 0,0, 0);
    set_in(0, 0, 1, 0);
    check_ready(1'b1);
    tick();
    check_outs(1,0,0, 0,0,0, 0,0, 1,0, 1);
    set_in(0, 0, 0, 0);
    tick();
    check("pscore", 8'(pscore), 8'd1);

`ifdef CARD_FORCE_EN
    // Dealer 9, 8, 7 -> 24 mod 10 = 4.
    tag = "force_full";
    set_in(0, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      force_card = 4'(9 - i);
      set_in(0, 0, 1, 1);
      tick();
    end
    set_in(0, 0, 0, 0);
    tick();
    check_outs(0,0,0, 9,8,7, 0,4, 0,3, 7);
    force_card = 4'd3;
    set_in(0, 0, 1, 1);
    check_ready(1'b0);
    tick();
    check_outs(0,0,0, 9,8,7, 0,4, 0,3, 7);
    force_card = 4'd5;
    set_in(0, 0, 1, 0);
    check_ready(1'b1);
    tick();
    check_outs(5,0,0, 9,8,7, 0,4, 1,3, 5);

    // Player 10, 12, 6 -> 6.
    tag = "force_mod";
    set_in(0, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      force_card = (i == 0) ? 4'd10 : (i == 1) ? 4'd12 : 4'd6;
      set_in(0, 0, 1, 0);
      tick();
    end
    set_in(0, 0, 0, 0);
    tick();
    check_outs(10,12,6, 0,0,0, 6,0, 3,0, 6);

    // Player 9, 9 -> 18 mod 10 = 8.
    set_in(0, 1, 0, 0);
    tick();
    force_card = 4'd9;
    set_in(0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0);
    tick();
    check_outs(9,9,0, 0,0,0, 8,0, 2,0, 9);

    // Out-of-range force falls back to the counter, which is 1 after reset.
    tag = "force_range";
    set_in(1, 0, 0, 0);
    tick();
    force_card = 4'd15;
    set_in(0, 0, 1, 0);
    tick();
    check_outs(1,0,0, 0,0,0, 0,0, 1,0, 1);
    set_in(0, 0, 0, 0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/card_deal_bank.md
Name: card_deal_bank

Overview:
- Upstream feeder for the 7-segment card decoders.
- Generates pseudo-random card values with a free-running 1..13 counter and accepts deal requests through a valid/ready handshake.
- Stores dealt cards in three player slots and three dealer slots. Each slot drives one 4-bit decoder input: 0 = blank, 1..13 = A..K.
- Computes a baccarat score for each hand.

Parameters:
SLOTS, 3, card slots per hand (fixed 3 for baccarat; pointers sized ceil(log2(SLOTS+1))).
CARD_MAX, 13, highest card code; counter wraps CARD_MAX -> 1.

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous hand clear (new round)
deal_valid  input  1  deal request
deal_to  input  1  target hand: 0 = player, 1 = dealer
deal_ready  output  1  request will be accepted this cycle
pcard1, pcard2, pcard3  output  4  player slot codes to decoders
dcard1, dcard2, dcard3  output  4  dealer slot codes to decoders
pscore  output  4  player score 0..9
dscore  output  4  dealer score 0..9
pcount  output  2  player cards held 0..3
dcount  output  2  dealer cards held 0..3
last_card  output  4  code of the most recently accepted card

Behaviour:
- Reset (reset=1 at an edge):
  - Counter goes to 1.
  - All card outputs, scores, counts and last_card go to 0.
  - Reset overrides clear and deal in the same cycle.
  - Reset mid-round discards all cards.
- Counter:
  - Increments every cycle, 1,2,...,13,1,...
  - Never holds 0 or 14..15.
  - Not affected by clear or deals.
- deal_ready:
  - Combinational: deal_ready = !clear && (deal_to ? dcount != 3 : pcount != 3).
  - Depends only on clear, deal_to and registered counts; never on deal_valid.
- Accept (deal_valid && deal_ready at an edge):
  - The current counter value is written into the target hand's slot at index count, and count increments.
  - Slot order is card1, then card2, then card3.
  - last_card takes the same value.
  - New card visible on the output the cycle after the accepting edge (latency 1).
  - One deal per cycle at most; back-to-back accepts are allowed every cycle.
- Full hand:
  - deal_valid toward a hand with count = 3 is not accepted.
  - No state changes, and the counter keeps running.
  - The other hand is unaffected.
- Clear:
  - Sets all six slots and both counts to 0, and the scores to 0.
  - Takes priority over a simultaneous deal_valid; deal_ready is 0 during clear, so nothing is accepted.
  - last_card is retained; counter continues.
- Score:
  - Card value is the code for 1..9, and 0 for 10..13 and blank.
  - Score = (v1 + v2 + v3) mod 10, computed with a 5-bit sum (max 27) and registered.
  - pscore/dscore reflect the slot registers with one extra cycle latency: valid 2 cycles after the accepting edge.
  - On clear the score goes to 0 at the same edge as the slots.
- All outputs registered except deal_ready.

Optional Feature:
- Macro: CARD_FORCE_EN.
- When defined:
  - Adds input force_card [3:0].
  - On accept, if force_card is in 1..13 the stored card is force_card instead of the counter value; otherwise the counter value is used.
  - The counter still free-runs.
- When undefined: no port is added, and cards always come from the counter.
- Intended for deterministic benches; board builds leave it undefined.

Test Plan:
1. Counter reset: hold reset 2 cycles, release; accept a player deal in the first cycle after release -> pcard1=1, pcount=1, last_card=1 one cycle later; pscore=1 one cycle after that.
2. Counter wrap: release reset, wait 12 cycles, deal player, next cycle deal player -> pcard1=13, pcard2=1, pscore=1.
3. Full hand: with CARD_FORCE_EN, force 9, 8, 7 to dealer -> dscore=4. A fourth dealer request gives deal_ready=0 and the dcard values hold; a simultaneous player request with force 5 is accepted -> pcard1=5.
4. Score mod: force player 10, 12, 6 -> pcard = 10, 12, 6; pscore=6. Force player 9, 9 -> pscore=8.
5. Clear priority: assert clear together with deal_valid for the player (pcount=2) -> deal_ready=0; next cycle all slots 0, pcount=0, pscore=0, last_card unchanged.
6. Reset mid-round: three player and two dealer cards held, pulse reset one cycle -> all outputs 0 the next cycle; a player deal one cycle after release yields pcard1=1.
